// File: rtl/oled_text_render.sv
// oled_text_render: draws the voltmeter text line "D.DDD V" into the
// 512x8 OLED display RAM. After reset it clears the whole frame, then it
// redraws the 56-byte text line each time a redraw is requested.
module oled_text_render #(
  parameter logic [1:0] TEXT_PAGE = 2'd1,
  parameter logic [6:0] TEXT_COL  = 7'd36
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [15:0] bcd_in,
  input  logic        update,
  output logic [6:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {CLEAR, IDLE, RENDER} state_t;

  localparam logic [9:0] CLEAR_END = 10'd512;  // all 512 bytes written
  localparam logic [5:0] RND_LAST  = 6'd56;    // issue slots 0..55
  localparam logic [5:0] RND_END   = 6'd57;    // cycle after the last write

  // BCD nibbles above 9 have no digit glyph and show as a blank
  function automatic logic [3:0] digit_glyph(input logic [3:0] d);
    return (d > 4'd9) ? 4'd11 : d;
  endfunction

  // Font ROM address for byte idx of the line: {glyph, column within glyph}
  function automatic logic [6:0] line_font_addr(input logic [15:0] bcd,
                                                input logic [5:0]  idx);
    logic [3:0] g;
    case (idx[5:3])
      3'd0:    g = digit_glyph(bcd[15:12]);
      3'd1:    g = 4'd10;                     // '.'
      3'd2:    g = digit_glyph(bcd[11:8]);
      3'd3:    g = digit_glyph(bcd[7:4]);
      3'd4:    g = digit_glyph(bcd[3:0]);
      3'd5:    g = 4'd11;                     // blank
      default: g = 4'd12;                     // 'V'
    endcase
    return {g, idx[2:0]};
  endfunction

  state_t      state_q, state_d;
  logic        start, finish;
  logic [9:0]  clr_cnt_q;
  logic [5:0]  rnd_cnt_q;
  logic        pending_q;
  logic [15:0] bcd_q;
  logic        s1_valid_q;
  logic [5:0]  s1_idx_q;
  logic        font_sel_q;
  logic [7:0]  data_q;
  logic        wr_en_q;
  logic [8:0]  wr_addr_q;
  logic [6:0]  font_addr_q;
  logic        busy_q;
  logic        done_q;
  logic        issue;
  logic        clear_wr;

  assign issue    = (state_q == RENDER) && (rnd_cnt_q < RND_LAST);
  assign clear_wr = (state_q == CLEAR) && (clr_cnt_q != CLEAR_END);

  // State register
  always_ff @(posedge clk_in) begin
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the values from before this edge, independent of block order.
    if (!rst_n_in) state_q <= CLEAR;
    else           state_q <= state_d;
  end

  // Next-state logic: start latches a new frame, finish ends the current one
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CLEAR_END) begin
          if (pending_q || update) begin
            start   = 1'b1;
            state_d = RENDER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (update) begin
          start   = 1'b1;
          state_d = RENDER;
        end
      end
      RENDER: begin
        if (rnd_cnt_q == RND_END) begin
          finish = 1'b1;
          if (pending_q || update) start   = 1'b1;
          else                     state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Datapath: clear counter, request latch, font fetch stage and RAM write stage
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      clr_cnt_q   <= '0;
      rnd_cnt_q   <= '0;
      pending_q   <= 1'b0;
      bcd_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      font_sel_q  <= 1'b0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      font_addr_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= finish;

      // One-deep request memory: later requests while busy coalesce
      if (start)                            pending_q <= 1'b0;
      else if (update && state_q != IDLE)   pending_q <= 1'b1;

      // The digits are frozen for the whole frame at the latch
      if (start) begin
        bcd_q     <= bcd_in;
        rnd_cnt_q <= '0;
      end else if (state_q == RENDER) begin
        rnd_cnt_q <= rnd_cnt_q + 6'd1;
      end

      // Stage 1: present the font address for byte rnd_cnt_q
      s1_valid_q <= issue;
      if (issue) begin
        font_addr_q <= line_font_addr(bcd_q, rnd_cnt_q);
        s1_idx_q    <= rnd_cnt_q;
      end

      // Stage 2: write the byte fetched in stage 1, or a clear byte
      font_sel_q <= s1_valid_q;
      if (clear_wr) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= clr_cnt_q[8:0];
        clr_cnt_q <= clr_cnt_q + 10'd1;
      end else begin
        wr_en_q <= s1_valid_q;
        if (s1_valid_q) wr_addr_q <= {TEXT_PAGE, TEXT_COL + {1'b0, s1_idx_q}};
      end

      // Remember the last written byte so wr_data holds once writes stop
      if (clear_wr)        data_q <= '0;
      else if (font_sel_q) data_q <= font_data;
    end
  end

  // The ROM answers one cycle after font_addr, exactly in the write cycle, so
  // render data passes straight through; otherwise the last byte is held.
  assign wr_data   = font_sel_q ? font_data : data_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign font_addr = font_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_oled_text_render.sv
// Testbench for oled_text_render: registered XOR font ROM, write recorder and
// a character-level reference model of the rendered text line.
module tb_oled_text_render;

  localparam int PAGE = 1;
  localparam int COL  = 36;

  logic        clk_in;
  logic        rst_n_in;
  logic [15:0] bcd_in;
  logic        update;
  logic [6:0]  font_addr;
  logic [7:0]  font_data;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  oled_text_render dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .bcd_in    (bcd_in),
    .update    (update),
    .font_addr (font_addr),
    .font_data (font_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Font ROM: data = addr ^ 8'hA5, one cycle of latency
  initial font_data = 8'h00;
  always @(posedge clk_in) font_data <= {1'b0, font_addr} ^ 8'hA5;

  // Recorder: every RAM write with the font address of the cycle before it
  logic [8:0] wa[$];
  logic [7:0] wd[$];
  logic [6:0] wfa[$];
  int         wcyc[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         busy_low_cnt = 0;
  logic [6:0] fa_prev = 7'h00;

  always @(negedge clk_in) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wfa.push_back(fa_prev);
      wcyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b0) busy_low_cnt <= busy_low_cnt + 1;
    fa_prev <= font_addr;
    cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;
  int wb, db, bb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Mark the start of a recording window
  task automatic mark();
    wb = wa.size();
    db = done_cnt;
    bb = busy_low_cnt;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    step(1);
    update = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  // Reference model: character code at text position pos (0..6)
  function automatic int char_code(input logic [15:0] bcd, input int pos);
    int nib;
    case (pos)
      0: nib = int'(bcd[15:12]);
      1: return 10;
      2: nib = int'(bcd[11:8]);
      3: nib = int'(bcd[7:4]);
      4: nib = int'(bcd[3:0]);
      5: return 11;
      default: return 12;
    endcase
    return (nib > 9) ? 11 : nib;
  endfunction

  function automatic logic [6:0] model_fa(input logic [15:0] bcd, input int k);
    return 7'(char_code(bcd, k / 8) * 8 + k % 8);
  endfunction

  function automatic logic [8:0] model_addr(input int k);
    return 9'(PAGE * 128 + COL + k);
  endfunction

  // Compare 56 recorded writes starting at queue index base with the model
  task automatic check_render(input string tag, input logic [15:0] bcd, input int base);
    for (int k = 0; k < 56; k++) begin
      check($sformatf("%s_addr%0d", tag, k), 32'(wa[base+k]), 32'(model_addr(k)));
      check($sformatf("%s_fa%0d", tag, k), 32'(wfa[base+k]), 32'(model_fa(bcd, k)));
      check($sformatf("%s_data%0d", tag, k), 32'(wd[base+k]), 32'(model_fa(bcd, k) ^ 7'h25) | 32'h80);
    end
  endtask

  // Compare 512 recorded clear writes starting at queue index base
  task automatic check_clear(input string tag, input int base);
    int bad_a = 0;
    int bad_d = 0;
    for (int k = 0; k < 512; k++) begin
      if (wa[base+k] !== 9'(k)) bad_a++;
      if (wd[base+k] !== 8'h00) bad_d++;
    end
    check({tag, "_addr_bad"}, 32'(bad_a), 32'd0);
    check({tag, "_data_bad"}, 32'(bad_d), 32'd0);
  endtask

  // Single render in IDLE; bcd_in is scrambled after the latch
  task automatic render_once(input string tag, input logic [15:0] bcd);
    int c0;
    mark();
    bcd_in = bcd;
    c0 = cyc;
    pulse_update();
    check({tag, "_busy_at_T"}, {31'd0, busy}, 32'd1);
    bcd_in = 16'($urandom);
    wait_done({tag, "_done_timeout"}, 200);
    check({tag, "_count"}, 32'(wa.size() - wb), 32'd56);
    check({tag, "_first_cyc"}, 32'(wcyc[wb]), 32'(c0 + 3));
    check({tag, "_done_after_last"}, 32'(wcyc[wb+55]), 32'(cyc - 1));
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check_render(tag, bcd, wb);
    step(1);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_hold_addr"}, 32'(wr_addr), 32'(model_addr(55)));
    check({tag, "_hold_data"}, 32'(wr_data), 32'(model_fa(bcd, 55) ^ 7'h25) | 32'h80);
    check({tag, "_done_cnt"}, 32'(done_cnt - db), 32'd1);
  endtask

  initial begin
    logic [15:0] a_bcd, b_bcd;
    int          first_done_last;
    int          n;

    rst_n_in = 1'b0;
    update   = 1'b0;
    bcd_in   = 16'h0000;

    // Reset values
    step(3);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Full clear after release
    mark();
    n = cyc;
    rst_n_in = 1'b1;
    wait_idle("clear_timeout", 1000);
    check("clear_count", 32'(wa.size() - wb), 32'd512);
    check("clear_first_cyc", 32'(wcyc[wb]), 32'(n + 1));
    check("clear_busy_fall", 32'(wcyc[wb+511]), 32'(cyc - 1));
    check_clear("clear", wb);
    check("clear_no_done", 32'(done_cnt - db), 32'd0);
    step(3);
    check("idle_wr_en", {31'd0, wr_en}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_hold_addr", 32'(wr_addr), 32'd511);
    check("idle_hold_data", 32'(wr_data), 32'd0);

    // Directed render with known byte values
    render_once("r3297", 16'h3297);
    check("r3297_w0_addr", 32'(wa[wb]), 32'h0A4);
    check("r3297_w0_data", 32'(wd[wb]), 32'hBD);
    check("r3297_w0_fa", 32'(wfa[wb]), 32'h18);
    check("r3297_w8_fa", 32'(wfa[wb+8]), 32'h50);
    check("r3297_w55_addr", 32'(wa[wb+55]), 32'h0DB);
    check("r3297_w55_fa", 32'(wfa[wb+55]), 32'h67);

    // Out-of-range nibbles render blank
    render_once("rA0F1", 16'hA0F1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rA0F1_blank0_%0d", k), 32'(wfa[wb+k]), 32'(8'h58 + k));
      check($sformatf("rA0F1_blank3_%0d", k), 32'(wfa[wb+24+k]), 32'(8'h58 + k));
    end

    // Random readings
    for (int r = 0; r < 4; r++) begin
      step(int'($urandom_range(0, 4)));
      render_once($sformatf("rnd%0d", r), 16'($urandom));
    end

    // Coalesced requests during a render, digits changed mid-frame
    a_bcd = 16'($urandom);
    b_bcd = a_bcd ^ 16'h5555;
    mark();
    bcd_in = a_bcd;
    pulse_update();
    bb = busy_low_cnt;
    step(5);
    pulse_update();
    step(10);
    bcd_in = b_bcd;
    pulse_update();
    step(5);
    pulse_update();
    wait_done("coal_done1_timeout", 200);
    check("coal_busy_at_done1", {31'd0, busy}, 32'd1);
    first_done_last = wcyc[wb+55];
    step(1);
    wait_done("coal_done2_timeout", 200);
    check("coal_busy_never_low", 32'(busy_low_cnt - bb), 32'd0);
    check("coal_count", 32'(wa.size() - wb), 32'd112);
    check("coal_restart_cyc", 32'(wcyc[wb+56]), 32'(first_done_last + 3));
    check_render("coal_f1", a_bcd, wb);
    check_render("coal_f2", b_bcd, wb + 56);
    step(70);
    check("coal_done_total", 32'(done_cnt - db), 32'd2);
    check("coal_no_third", 32'(wa.size() - wb), 32'd112);
    check("coal_idle", {31'd0, busy}, 32'd0);

    // Request during the clear: render follows write 511 with no IDLE cycle
    rst_n_in = 1'b0;
    step(1);
    a_bcd = 16'($urandom);
    bcd_in = a_bcd;
    mark();
    rst_n_in = 1'b1;
    step(100);
    pulse_update();
    wait_done("clrupd_timeout", 1000);
    check("clrupd_count", 32'(wa.size() - wb), 32'd568);
    check_clear("clrupd", wb);
    check_render("clrupd_r", a_bcd, wb + 512);
    check("clrupd_gap", 32'(wcyc[wb+512]), 32'(wcyc[wb+511] + 3));
    check("clrupd_busy_never_low", 32'(busy_low_cnt - bb), 32'd0);
    step(2);

    // Reset at render write 20 aborts the frame and drops the pending request
    mark();
    bcd_in = 16'($urandom);
    pulse_update();
    step(3);
    pulse_update();
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr === model_addr(20)) && n < 100) begin
      step(1);
      n++;
    end
    check("abort_reach_w20", 32'(wr_addr), 32'(model_addr(20)));
    rst_n_in = 1'b0;
    step(1);
    check("abort_wr_en", {31'd0, wr_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    check("abort_font_addr", 32'(font_addr), 32'd0);
    mark();
    rst_n_in = 1'b1;
    wait_idle("abort_clear_timeout", 1000);
    check("abort_clear_count", 32'(wa.size() - wb), 32'd512);
    check_clear("abort_clear", wb);
    step(70);
    check("abort_pending_lost", 32'(wa.size() - wb), 32'd512);
    check("abort_no_done", 32'(done_cnt - db), 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
